multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multi-cycle main control FSM for the RISC-V core. It sits upstream of the ALU control decoder and produces the `alu_op` / `func_op` pair that the decoder consumes. It also sequences instruction fetch, memory access and register write-back with a ready handshake to the unified memory port. Supported instruction classes are R, I-ALU, LOAD, STORE, BRANCH (beq/bne) and JAL. Any other opcode traps.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `instr`  in  32  IR contents from the datapath; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current `mem_req` this cycle.
- `alu_zero`  in  1  ALU zero flag, valid in EXEC.
- `alu_op`  out  2  class code: LSJ=2'b00, B=2'b01, R=2'b10, I=2'b11.
- `func_op`  out  4  {instr[30], instr[14:12]} for R; {1'b0, instr[14:12]} for I; 4'b0 otherwise.
- `alu_src_b`  out  1  0 = rs2, 1 = immediate.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write (store).
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  load IR.
- `pc_we`  out  1  PC write enable.
- `pc_sel`  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- `reg_we`  out  1  register file write.
- `wb_sel`  out  2  00 = ALU, 01 = memory data, 10 = PC+4 (link).
- `state`  out  3  current state code, for debug.
- `illegal`  out  1  sticky trap flag.
- `instret`  out  32  count of retired instructions.

## Operation
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6–7 are unreachable and recover to FETCH.
- Outputs are Moore-style decodes of `state` plus the registered class. The exceptions are `pc_we` in EXEC and outputs gated by `mem_ready`.
- Any output not listed for a state is 0.

**FETCH**
- `mem_req`=1, `iord`=0.
- When `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_sel`=00, and the FSM moves to DECODE.
- Otherwise it stays in FETCH with the request held.

**DECODE**
- Registers the class from `instr[6:0]`:
  - 0110011 R
  - 0010011 I
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1101111 JAL
- Registers `func_op` for use in later states, so IR changes after DECODE are ignored.
- A BRANCH with funct3 other than 000/001 counts as unsupported.
- Unsupported opcode → TRAP; otherwise → EXEC.

**EXEC**
- R: `alu_op`=R, `alu_src_b`=0 → WB.
- I: `alu_op`=I, `alu_src_b`=1 → WB.
- LOAD/STORE: `alu_op`=LSJ, `alu_src_b`=1 → MEM.
- BRANCH:
  - `alu_op`=B, `alu_src_b`=0, `pc_sel`=01.
  - `pc_we` = `alu_zero` for beq, `!alu_zero` for bne.
  - → FETCH; the instruction retires.
- JAL: `pc_we`=1, `pc_sel`=10, `reg_we`=1, `wb_sel`=10 → FETCH; the instruction retires.

**MEM**
- `mem_req`=1, `iord`=1, `alu_op`=LSJ, `alu_src_b`=1, `mem_we` = (class==STORE).
- On `mem_ready`: STORE → FETCH (retires); LOAD → WB.
- Without `mem_ready`, stays in MEM.

**WB**
- `reg_we`=1, `wb_sel` = 01 for LOAD, 00 otherwise → FETCH; the instruction retires.

**TRAP**
- `illegal`=1. No bus or write activity.
- The FSM stays in TRAP until reset.

**instret**
- Increments by 1 on each retiring transition and wraps at 2^32−1 → 0.

## Timing
- Reset (`rst_n` low, asynchronous): `state`=FETCH, class and `func_op` cleared, `instret`=0, `illegal`=0.
- While `rst_n` is low, every control output is forced to 0, including `mem_req`.
- `mem_req` first asserts in the first cycle after `rst_n` rises.
- Latency with zero-wait memory, in cycles: R/I = 4, LOAD = 5, STORE = 4, BRANCH = 3, JAL = 3.
- Each wait cycle in FETCH or MEM adds 1 cycle. `mem_req`, `mem_we` and `iord` stay stable while waiting.
- `mem_ready` while `mem_req`=0 is ignored.
- Reset asserted mid-instruction aborts it: no `reg_we` or `pc_we` pulse after reset, and `instret` is not incremented.
- An `instret` increment and the return to FETCH happen on the same edge.

## Test plan
- Reset, then `instr`=0x002081B3 (add) with `mem_ready` tied 1 → state sequence 0,1,2,4,0; EXEC shows `alu_op`=2'b10, `func_op`=4'b0000; one `reg_we` pulse with `wb_sel`=00; `instret`=1.
- Sub 0x402081B3, then addi 0x00500093 → EXEC `func_op`=4'b1000 for sub; for addi `alu_op`=2'b11, `func_op`=4'b0000, `alu_src_b`=1.
- lw 0x0000A283 with `mem_ready` low for 3 MEM cycles → `mem_req`=1, `iord`=1, `mem_we`=0 held for 4 cycles; WB `wb_sel`=01; total 8 cycles. sw 0x0050A023 → `mem_we`=1 in MEM, no `reg_we`.
- beq 0x00000063 with `alu_zero`=1 → `pc_we`=1, `pc_sel`=01 in EXEC; same instruction with `alu_zero`=0 → `pc_we`=0. Both back in FETCH after 3 cycles.
- `instr`=0x0000007F → DECODE→TRAP, `illegal`=1 held; no `mem_req` for 20 cycles; `rst_n` pulse clears to FETCH.
- Async reset asserted in WB of an add → outputs 0 immediately, no `reg_we` edge, `instret` unchanged at 0; fetch resumes after release.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle main control FSM: sequences fetch/decode/exec/mem/wb and emits alu_op/func_op for the ALU decoder.
// Latency R/I=4, LOAD=5, STORE=4, BRANCH/JAL=3 cycles; FETCH and MEM stall while mem_ready is low.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [1:0]  alu_op,
    output logic [3:0]  func_op,
    output logic        alu_src_b,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL
    } class_e;

    localparam logic [1:0] OP_LSJ = 2'b00;
    localparam logic [1:0] OP_B   = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;

    state_e      state_q, state_d;
    class_e      class_q, class_d;
    logic [3:0]  func_op_q, func_op_d;
    logic        br_ne_q, br_ne_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    logic [1:0]  alu_op_c, pc_sel_c, wb_sel_c;
    logic [3:0]  func_op_c;
    logic        alu_src_b_c, mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c, reg_we_c, illegal_c;

    // Only opcode, funct3 and instr[30] steer control.
    logic unused_instr;
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            class_q   <= C_NONE;
            func_op_q <= 4'b0;
            br_ne_q   <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            func_op_q <= func_op_d;
            br_ne_q   <= br_ne_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        func_op_d   = func_op_q;
        br_ne_d     = br_ne_q;
        retire      = 1'b0;
        alu_op_c    = OP_LSJ;
        func_op_c   = 4'b0;
        alu_src_b_c = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_sel_c    = 2'b00;
        reg_we_c    = 1'b0;
        wb_sel_c    = 2'b00;
        illegal_c   = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                func_op_d = 4'b0;
                br_ne_d   = 1'b0;
                case (instr[6:0])
                    7'b0110011: begin
                        class_d   = C_R;
                        func_op_d = {instr[30], instr[14:12]};
                    end
                    7'b0010011: begin
                        class_d   = C_I;
                        func_op_d = {1'b0, instr[14:12]};
                    end
                    7'b0000011: class_d = C_LOAD;
                    7'b0100011: class_d = C_STORE;
                    7'b1100011: begin
                        // Only beq/bne are supported; other funct3 values trap.
                        class_d = (instr[14:13] == 2'b00) ? C_BRANCH : C_NONE;
                        br_ne_d = instr[12];
                    end
                    7'b1101111: class_d = C_JAL;
                    default:    class_d = C_NONE;
                endcase
                state_d = (class_d == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                func_op_c = func_op_q;
                case (class_q)
                    C_R: begin
                        alu_op_c = OP_R;
                        state_d  = S_WB;
                    end
                    C_I: begin
                        alu_op_c    = OP_I;
                        alu_src_b_c = 1'b1;
                        state_d     = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_op_c    = OP_LSJ;
                        alu_src_b_c = 1'b1;
                        state_d     = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_op_c = OP_B;
                        pc_sel_c = 2'b01;
                        pc_we_c  = br_ne_q ? !alu_zero : alu_zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    C_JAL: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = 2'b10;
                        reg_we_c = 1'b1;
                        wb_sel_c = 2'b10;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req_c   = 1'b1;
                iord_c      = 1'b1;
                alu_op_c    = OP_LSJ;
                alu_src_b_c = 1'b1;
                func_op_c   = func_op_q;
                mem_we_c    = (class_q == C_STORE);
                if (mem_ready) begin
                    if (class_q == C_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                wb_sel_c = (class_q == C_LOAD) ? 2'b01 : 2'b00;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: illegal_c = 1'b1;
            default: state_d = S_FETCH;
        endcase

        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    // Control outputs are held low for as long as reset is asserted.
    always_comb begin
        alu_op    = rst_n ? alu_op_c  : 2'b0;
        func_op   = rst_n ? func_op_c : 4'b0;
        alu_src_b = rst_n & alu_src_b_c;
        mem_req   = rst_n & mem_req_c;
        mem_we    = rst_n & mem_we_c;
        iord      = rst_n & iord_c;
        ir_we     = rst_n & ir_we_c;
        pc_we     = rst_n & pc_we_c;
        pc_sel    = rst_n ? pc_sel_c : 2'b0;
        reg_we    = rst_n & reg_we_c;
        wb_sel    = rst_n ? wb_sel_c : 2'b0;
        illegal   = rst_n & illegal_c;
        state     = state_q;
        instret   = instret_q;
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class through its state sequence.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic [1:0]  alu_op;
    logic [3:0]  func_op;
    logic        alu_src_b, mem_req, mem_we, iord, ir_we, pc_we, reg_we, illegal;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .alu_op(alu_op), .func_op(func_op), .alu_src_b(alu_src_b), .mem_req(mem_req),
        .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .illegal(illegal), .instret(instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        int reg_we_seen;
        int req_seen;
        rst_n     = 1'b0;
        instr     = 32'h002081B3;
        mem_ready = 1'b1;
        alu_zero  = 1'b0;

        // Reset state
        nxt();
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_instret", instret, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        #1;
        chk("fetch_req", {mem_req, iord, ir_we, pc_we}, 4'b1011);

        // add
        nxt(); chk("add_dec", state, 1);
        nxt(); chk("add_exec_state", state, 2);
        chk("add_exec_op", {alu_op, func_op, alu_src_b, reg_we}, {2'b10, 4'b0000, 1'b0, 1'b0});
        nxt(); chk("add_wb", {state, reg_we, wb_sel}, {3'd4, 1'b1, 2'b00});
        nxt(); chk("add_done", {state, 1'b0, instret}, {3'd0, 1'b0, 32'd1});

        // sub
        instr = 32'h402081B3;
        nxt(); nxt(); chk("sub_exec", {state, alu_op, func_op}, {3'd2, 2'b10, 4'b1000});
        nxt(); nxt(); chk("sub_done", instret, 2);

        // addi
        instr = 32'h00500093;
        nxt(); nxt(); chk("addi_exec", {state, alu_op, func_op, alu_src_b}, {3'd2, 2'b11, 4'b0000, 1'b1});
        nxt(); chk("addi_wb", {state, reg_we, wb_sel}, {3'd4, 1'b1, 2'b00});
        nxt(); chk("addi_done", {state, instret}, {3'd0, 32'd3});

        // lw with three MEM wait cycles: 8 cycles total
        instr = 32'h0000A283;
        nxt(); nxt(); chk("lw_exec", {state, alu_op, alu_src_b}, {3'd2, 2'b00, 1'b1});
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (i == 3) mem_ready = 1'b1;
            chk("lw_mem_hold", {state, mem_req, iord, mem_we}, {3'd3, 1'b1, 1'b1, 1'b0});
        end
        nxt(); chk("lw_wb", {state, reg_we, wb_sel}, {3'd4, 1'b1, 2'b01});
        nxt(); chk("lw_done", {state, instret}, {3'd0, 32'd4});

        // sw
        instr = 32'h0050A023;
        nxt(); nxt(); nxt();
        chk("sw_mem", {state, mem_req, iord, mem_we, reg_we}, {3'd3, 1'b1, 1'b1, 1'b1, 1'b0});
        nxt(); chk("sw_done", {state, instret}, {3'd0, 32'd5});

        // beq taken
        instr = 32'h00000063;
        alu_zero = 1'b1;
        nxt(); nxt(); chk("beq_t_exec", {state, alu_op, pc_we, pc_sel}, {3'd2, 2'b01, 1'b1, 2'b01});
        nxt(); chk("beq_t_done", {state, instret}, {3'd0, 32'd6});

        // beq not taken
        alu_zero = 1'b0;
        nxt(); nxt(); chk("beq_nt_exec", {state, pc_we, pc_sel}, {3'd2, 1'b0, 2'b01});
        nxt(); chk("beq_nt_done", {state, instret}, {3'd0, 32'd7});

        // jal
        instr = 32'h0000006F;
        nxt(); nxt();
        chk("jal_exec", {state, pc_we, pc_sel, reg_we, wb_sel}, {3'd2, 1'b1, 2'b10, 1'b1, 2'b10});
        nxt(); chk("jal_done", {state, instret}, {3'd0, 32'd8});

        // Illegal opcode traps and holds
        instr = 32'h0000007F;
        nxt(); chk("trap_dec", state, 1);
        nxt(); chk("trap_enter", {state, illegal}, {3'd5, 1'b1});
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            nxt();
            if (mem_req || state != 3'd5 || !illegal) req_seen++;
        end
        chk("trap_hold", req_seen, 0);
        rst_n = 1'b0;
        #1;
        chk("trap_rst", {state, illegal, mem_req, instret}, {3'd0, 1'b0, 1'b0, 32'd0});
        nxt();
        rst_n = 1'b1;

        // Reset in WB of an add aborts it
        instr = 32'h002081B3;
        nxt(); nxt(); nxt();
        chk("abort_wb", {state, reg_we}, {3'd4, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outs", {state, reg_we, pc_we, mem_req, instret}, {3'd0, 1'b0, 1'b0, 1'b0, 32'd0});
        reg_we_seen = 0;
        nxt();
        if (reg_we || pc_we) reg_we_seen++;
        rst_n = 1'b1;
        #1;
        chk("abort_quiet", reg_we_seen, 0);
        chk("resume_fetch", {state, mem_req, instret}, {3'd0, 1'b1, 32'd0});
        nxt(); nxt(); nxt(); nxt();
        chk("resume_done", {state, instret}, {3'd0, 32'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
